// File: rtl/fmap_stream_tx.sv
// Captures per-channel feature maps (one active, one pending) and streams them out row-major over valid/ready.
// Define FMAP_RELU_SAT_EN to clamp negative elements to zero at the output.
module fmap_stream_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int H          = 12,
    parameter int W          = 11,
    parameter int CHAN       = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [3:0]                   in_chan,
    input  logic signed [DATA_WIDTH-1:0] in_fmap [0:H-1][0:W-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [3:0]                   out_row,
    output logic [3:0]                   out_col,
    output logic [3:0]                   out_chan,
    output logic                         out_last,
    output logic                         out_img_done,
    output logic                         busy,
    output logic                         overflow
);

    localparam logic [3:0] ROW_LAST  = 4'(H - 1);
    localparam logic [3:0] COL_LAST  = 4'(W - 1);
    localparam logic [3:0] CHAN_LAST = 4'(CHAN - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t state_reg, state_next;

    logic signed [DATA_WIDTH-1:0] act_mem  [0:H-1][0:W-1];
    logic signed [DATA_WIDTH-1:0] pend_mem [0:H-1][0:W-1];

    logic [3:0] row_reg, col_reg, chan_reg, pend_chan_reg;
    logic       pend_full_reg, overflow_reg, img_done_reg;

    logic at_end, xfer, final_xfer;
    logic load_act_in, load_act_pend, load_pend, drop;
    logic signed [DATA_WIDTH-1:0] elem;

    assign at_end     = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign xfer       = (state_reg == S_STREAM) && out_ready;
    assign final_xfer = xfer && at_end;

    // A map arriving on the final transfer goes straight to active when nothing is pending,
    // otherwise it refills the pending slot that is being promoted in the same cycle.
    assign load_act_in   = ((state_reg == S_IDLE) && in_valid) ||
                           (final_xfer && in_valid && !pend_full_reg);
    assign load_act_pend = final_xfer && pend_full_reg;
    assign load_pend     = (state_reg == S_STREAM) && in_valid &&
                           (final_xfer ? pend_full_reg : !pend_full_reg);
    assign drop          = (state_reg == S_STREAM) && in_valid && !final_xfer && pend_full_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (in_valid) state_next = S_STREAM;
            S_STREAM: if (final_xfer && !pend_full_reg && !in_valid) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg       <= '0;
            col_reg       <= '0;
            chan_reg      <= '0;
            pend_chan_reg <= '0;
            pend_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            img_done_reg  <= 1'b0;
        end else begin
            img_done_reg <= final_xfer && (chan_reg == CHAN_LAST);
            if (drop) overflow_reg <= 1'b1;

            if (load_act_in)        chan_reg <= in_chan;
            else if (load_act_pend) chan_reg <= pend_chan_reg;
            if (load_pend) pend_chan_reg <= in_chan;

            if (final_xfer)     pend_full_reg <= pend_full_reg && in_valid;
            else if (load_pend) pend_full_reg <= 1'b1;

            if (load_act_in || load_act_pend) begin
                row_reg <= '0;
                col_reg <= '0;
            end else if (xfer) begin
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 4'd1;
                end else begin
                    col_reg <= col_reg + 4'd1;
                end
            end
        end
    end

    // Map storage needs no reset: the slot flags decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (load_act_in)        act_mem[r][c] <= in_fmap[r][c];
                else if (load_act_pend) act_mem[r][c] <= pend_mem[r][c];
                if (load_pend)          pend_mem[r][c] <= in_fmap[r][c];
            end
        end
    end

    always_comb begin
        out_valid    = (state_reg == S_STREAM);
        out_last     = out_valid && at_end;
        busy         = out_valid || pend_full_reg;
        overflow     = overflow_reg;
        out_img_done = img_done_reg;
        out_row      = row_reg;
        out_col      = col_reg;
        out_chan     = chan_reg;
        elem         = out_valid ? act_mem[row_reg][col_reg] : '0;
`ifdef FMAP_RELU_SAT_EN
        out_data     = elem[DATA_WIDTH-1] ? '0 : elem;
`else
        out_data     = elem;
`endif
    end

endmodule
